// File: rtl/karatsuba_pkg.sv
// Shared types and elaboration-time helpers for the digit-serial Karatsuba GF(2)[x] multiplier.
package karatsuba_pkg;

    // IDLE: waiting | RUN: digit-serial half products | COMBINE: XOR recombination | DONE: c fresh
    typedef enum logic [1:0] {IDLE, RUN, COMBINE, DONE} state_e;

    function automatic int ceil_half(input int n);
        return (n + 1) / 2;
    endfunction

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/gf2_digit_mac.sv
// Digit-serial carry-less multiply-accumulate: consumes DIGIT multiplier bits per step,
// shifting the multiplicand left instead of the accumulator.
module gf2_digit_mac
    import karatsuba_pkg::*;
#(
    parameter int W     = 142,
    parameter int DIGIT = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic [2*W-2:0] acc
);

    localparam int PW = 2 * W - 1;

    logic [W-1:0]  x_q, x_d;
    logic [PW-1:0] y_q, y_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [PW-1:0] pp;

    // Multiplicand bits pushed past PW-1 can only meet zero multiplier bits, so truncation is exact.
    always_comb begin
        pp = '0;
        for (int d = 0; d < DIGIT; d++) begin
            if (x_q[d]) pp = pp ^ (y_q << d);
        end
        x_d   = x_q;
        y_d   = y_q;
        acc_d = acc_q;
        if (load) begin
            x_d   = x;
            y_d   = PW'(y);
            acc_d = '0;
        end else if (step) begin
            x_d   = x_q >> DIGIT;
            y_d   = y_q << DIGIT;
            acc_d = acc_q ^ pp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q   <= '0;
            y_q   <= '0;
            acc_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/karatsuba_gf2_mul_seq.sv
// Two-way Karatsuba carry-less multiplier: three digit-serial half products in parallel,
// recombined with XORs into a registered 2N-bit result.
module karatsuba_gf2_mul_seq
    import karatsuba_pkg::*;
#(
    parameter int N     = 283,
    parameter int DIGIT = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] c
);

    localparam int H     = ceil_half(N);
    localparam int ITER  = ceil_div(H, DIGIT);
    localparam int CNT_W = $clog2(ITER + 1);
    localparam int PW    = 2 * H - 1;
    localparam int CW    = 2 * N;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]      c_q, c_d;
    logic               accept;
    logic               step;

    logic [H-1:0]  a_lo, a_hi, b_lo, b_hi;
    logic [PW-1:0] p0, p1, p2;
    logic [CW-1:0] full;

    assign a_lo = a[H-1:0];
    assign a_hi = H'(a[N-1:H]);
    assign b_lo = b[H-1:0];
    assign b_hi = H'(b[N-1:H]);

    gf2_digit_mac #(.W(H), .DIGIT(DIGIT)) u_mac_p0 (
        .clk(clk), .rst(rst), .load(accept), .step(step), .x(a_lo), .y(b_lo), .acc(p0)
    );
    gf2_digit_mac #(.W(H), .DIGIT(DIGIT)) u_mac_p1 (
        .clk(clk), .rst(rst), .load(accept), .step(step), .x(a_lo ^ a_hi), .y(b_lo ^ b_hi), .acc(p1)
    );
    gf2_digit_mac #(.W(H), .DIGIT(DIGIT)) u_mac_p2 (
        .clk(clk), .rst(rst), .load(accept), .step(step), .x(a_hi), .y(b_hi), .acc(p2)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = CNT_W'(ITER);
                    accept  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = COMBINE;
            end
            COMBINE: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Terms landing at or above bit 2N are mathematically zero, so the CW-wide shifts lose nothing.
    always_comb begin
        full = CW'(p0) ^ (CW'(p0 ^ p1 ^ p2) << H) ^ (CW'(p2) << (2 * H));
        c_d  = (state_q == COMBINE) ? full : c_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
        end
    end

    assign ready = (state_q == IDLE) || (state_q == DONE);
    assign busy  = (state_q == RUN) || (state_q == COMBINE);
    assign done  = (state_q == DONE);
    assign c     = c_q;

endmodule

// File: tb/tb_karatsuba_gf2_mul_seq.sv
// Directed and random checks of the Karatsuba multiplier against a bitwise carry-less model.
module tb_karatsuba_gf2_mul_seq;

    localparam int N     = 283;
    localparam int DIGIT = 8;
    localparam int ITER  = 18;
    localparam int LAT   = ITER + 2;
    localparam int N2    = 17;
    localparam int D2    = 9;
    localparam int LAT2  = 3;

    typedef logic [N-1:0]   op_t;
    typedef logic [2*N-1:0] prod_t;

    typedef struct {
        string name;
        op_t   a;
        op_t   b;
        prod_t exp;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          start;
    op_t           a, b;
    logic          ready, busy, done;
    prod_t         c;

    logic          start2;
    logic [N2-1:0] a2, b2;
    logic          ready2, busy2, done2;
    logic [2*N2-1:0] c2;

    int tests = 0;
    int fails = 0;

    karatsuba_gf2_mul_seq #(.N(N), .DIGIT(DIGIT)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .ready(ready), .busy(busy), .done(done), .c(c)
    );

    karatsuba_gf2_mul_seq #(.N(N2), .DIGIT(D2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
        .ready(ready2), .busy(busy2), .done(done2), .c(c2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic prod_t clmul(input op_t x, input op_t y);
        prod_t r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (y[i]) r = r ^ (prod_t'(x) << i);
        end
        return r;
    endfunction

    function automatic op_t rnd();
        op_t r;
        r = '0;
        for (int i = 0; i < 9; i++) r = (r << 32) | op_t'($urandom);
        return r;
    endfunction

    task automatic chk(input string nm, input prod_t act, input prod_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Call just after a negedge with the DUT ready; returns at the negedge where done is seen.
    task automatic do_op(input op_t ai, input op_t bi, output prod_t co, output int lat);
        a     = ai;
        b     = bi;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~ai;
        b     = ~bi;
        lat   = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
        co = c;
    endtask

    task automatic do_op2(input logic [N2-1:0] ai, input logic [N2-1:0] bi,
                          output logic [2*N2-1:0] co, output int lat);
        a2     = ai;
        b2     = bi;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        a2     = ~ai;
        b2     = ~bi;
        lat    = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (done2) break;
        end
        co = c2;
    endtask

    // c may only move on a done cycle or after a reset edge; its top bit is always 0.
    initial begin
        prod_t c_prev;
        logic  r_e;
        c_prev = '0;
        forever begin
            @(posedge clk);
            r_e = rst;
            @(negedge clk);
            if (c !== c_prev && !done && !r_e) begin
                fails++;
                $display("FAIL c_stable: got %h expected %h", c, c_prev);
            end
            if (c[2*N-1] !== 1'b0) begin
                fails++;
                $display("FAIL c_msb: got %b expected 0", c[2*N-1]);
            end
            c_prev = c;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t  vecs[9];
        op_t   one, hi, ones;
        op_t   a1, b1;
        prod_t got;
        logic [2*N2-1:0] got2;
        logic [N2-1:0]   r2a, r2b;
        prod_t ext;
        int    lat, pulses;

        one  = op_t'(1);
        hi   = one << (N - 1);
        ones = '1;
        vecs[0] = '{"t1_one",       one,              one,             prod_t'(1)};
        vecs[1] = '{"t2_top",       hi,               hi,              prod_t'(1) << (2*N - 2)};
        vecs[2] = '{"t3_three",     op_t'(3),         op_t'(3),        prod_t'(5)};
        vecs[3] = '{"t3_ones",      ones,             one,             prod_t'(ones)};
        vecs[4] = '{"t6_a_zero",    op_t'(0),         op_t'(32'h1234567), prod_t'(0)};
        vecs[5] = '{"t6_b_zero",    op_t'(32'hdeadbeef), op_t'(0),     prod_t'(0)};
        vecs[6] = '{"x2x_times_x1", op_t'(6),         op_t'(3),        prod_t'(10)};
        vecs[7] = '{"x2p1_squared", op_t'(5),         op_t'(5),        prod_t'(17)};
        vecs[8] = '{"ends_squared", hi | one,         hi | one,        (prod_t'(1) << (2*N - 2)) | prod_t'(1)};

        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        start2 = 1'b0;
        a2     = '0;
        b2     = '0;
        repeat (3) @(negedge clk);
        chk("reset_c",     c,              prod_t'(0));
        chk("reset_ready", prod_t'(ready), prod_t'(1));
        chk("reset_busy",  prod_t'(busy),  prod_t'(0));
        chk("reset_done",  prod_t'(done),  prod_t'(0));
        rst = 1'b0;
        @(negedge clk);

        // Table vectors run back to back: each start lands in the previous DONE cycle.
        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].a, vecs[i].b, got, lat);
            chk(vecs[i].name, got, vecs[i].exp);
            chk({vecs[i].name, "_lat"}, prod_t'(lat), prod_t'(LAT));
        end

        for (int i = 0; i < 1000; i++) begin
            a1 = rnd();
            b1 = rnd();
            do_op(a1, b1, got, lat);
            chk("t4_rand", got, clmul(a1, b1));
            chk("t4_lat", prod_t'(lat), prod_t'(LAT));
        end

        // Start pulses with fresh operands during RUN must not disturb the operation in flight.
        @(negedge clk);
        a1    = rnd();
        b1    = rnd();
        a     = a1;
        b     = b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (done) break;
            if (lat >= 3 && lat <= 6) begin
                start = 1'b1;
                a     = rnd();
                b     = rnd();
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("t5_ignore_c",   c,            clmul(a1, b1));
        chk("t5_ignore_lat", prod_t'(lat), prod_t'(LAT));

        // Reset at RUN step 5: result cleared, back to ready, no done pulse afterwards.
        @(negedge clk);
        a     = rnd();
        b     = rnd();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_busy_before_rst", prod_t'(busy), prod_t'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_c",     c,              prod_t'(0));
        chk("t5_rst_ready", prod_t'(ready), prod_t'(1));
        chk("t5_rst_busy",  prod_t'(busy),  prod_t'(0));
        pulses = 0;
        for (int i = 0; i < LAT + 2; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        chk("t5_no_done", prod_t'(pulses), prod_t'(0));

        // Reset and start in the same cycle: reset wins.
        rst   = 1'b1;
        start = 1'b1;
        a     = op_t'(5);
        b     = op_t'(5);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy",  prod_t'(busy),  prod_t'(0));
        chk("rst_start_ready", prod_t'(ready), prod_t'(1));

        do_op(op_t'(0), rnd(), got, lat);
        chk("t6_zero_after_rst",     got,          prod_t'(0));
        chk("t6_zero_after_rst_lat", prod_t'(lat), prod_t'(LAT));

        // Second instance: N=17, DIGIT=H=9, so ITER=1 and done follows two cycles after acceptance.
        do_op2('1, '1, got2, lat);
        chk("n17_ones_sq",     prod_t'(got2), prod_t'(34'h155555555));
        chk("n17_ones_sq_lat", prod_t'(lat),  prod_t'(LAT2));
        do_op2(17'd3, 17'd3, got2, lat);
        chk("n17_three",     prod_t'(got2), prod_t'(5));
        chk("n17_three_lat", prod_t'(lat),  prod_t'(LAT2));
        for (int i = 0; i < 20; i++) begin
            r2a = N2'($urandom);
            r2b = N2'($urandom);
            do_op2(r2a, r2b, got2, lat);
            ext = clmul(op_t'(r2a), op_t'(r2b));
            chk("n17_rand",     prod_t'(got2), prod_t'(ext[2*N2-1:0]));
            chk("n17_rand_lat", prod_t'(lat),  prod_t'(LAT2));
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
